// File: rtl/alu_seq_exec.sv
// Sequential ALU execute unit: single-cycle logic/arithmetic/compare ops,
// iterative one-bit-per-cycle shifter, start/busy/done handshake.
module alu_seq_exec #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  Zero
);

   localparam int SHAMT_W = $clog2(DATA_WIDTH);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0011;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SRA = 4'b0111;
   localparam logic [3:0] OP_EQ  = 4'b1000;
   localparam logic [3:0] OP_SLT = 4'b1100;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [3:0]            r_op;
   logic [DATA_WIDTH-1:0] r_shreg;
   logic [SHAMT_W-1:0]    r_cnt;
   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_zero;

   logic [DATA_WIDTH-1:0] w_alu_result;
   logic [DATA_WIDTH-1:0] w_shifted;
   logic [SHAMT_W-1:0]    w_shamt;
   logic                  w_is_shift;
   logic                  w_start_shift;
   logic                  w_last_step;

   assign w_shamt       = SrcB[SHAMT_W-1:0];
   assign w_is_shift    = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);
   assign w_start_shift = w_is_shift && (w_shamt != '0);
   assign w_last_step   = (r_cnt == SHAMT_W'(1));

   // Single-cycle result; shift codes land here only with amount 0, so they pass A.
   always_comb begin
      // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
      w_alu_result = '0;
      case (Operation)
         OP_AND:  w_alu_result = SrcA & SrcB;
         OP_OR:   w_alu_result = SrcA | SrcB;
         OP_ADD:  w_alu_result = SrcA + SrcB;
         OP_XOR:  w_alu_result = SrcA ^ SrcB;
         OP_SUB:  w_alu_result = SrcA - SrcB;
         OP_SLL,
         OP_SRL,
         OP_SRA:  w_alu_result = SrcA;
         OP_EQ:   w_alu_result = DATA_WIDTH'(SrcA == SrcB);
         OP_SLT:  w_alu_result = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
         default: w_alu_result = '0;
      endcase
   end

   always_comb begin
      w_shifted = r_shreg;
      case (r_op)
         OP_SLL:  w_shifted = {r_shreg[DATA_WIDTH-2:0], 1'b0};
         OP_SRL:  w_shifted = {1'b0, r_shreg[DATA_WIDTH-1:1]};
         OP_SRA:  w_shifted = {r_shreg[DATA_WIDTH-1], r_shreg[DATA_WIDTH-1:1]};
         default: w_shifted = r_shreg;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      busy         = (r_state != S_IDLE);
      done         = (r_state == S_DONE);
      case (r_state)
         S_IDLE:  if (start) w_next_state = w_start_shift ? S_SHIFT : S_DONE;
         S_SHIFT: if (w_last_step) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Reset clears the result too, so an aborted shift leaves no stale value behind.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op     <= '0;
         r_shreg  <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_zero   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op <= Operation;
                  if (w_start_shift) begin
                     r_shreg <= SrcA;
                     r_cnt   <= w_shamt;
                  end else begin
                     r_result <= w_alu_result;
                     r_zero   <= (w_alu_result == '0);
                  end
               end
            end
            S_SHIFT: begin
               r_shreg <= w_shifted;
               r_cnt   <= r_cnt - SHAMT_W'(1);
               if (w_last_step) begin
                  r_result <= w_shifted;
                  r_zero   <= (w_shifted == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign ALUResult = r_result;
   assign Zero      = r_zero;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed vector table, random ops
// against an arithmetic reference model, and handshake/reset sequences.
module tb_alu_seq_exec;

   localparam int DW     = 32;
   localparam int BUDGET = 40;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [3:0]    Operation;
   logic [DW-1:0] SrcA;
   logic [DW-1:0] SrcB;
   logic          busy;
   logic          done;
   logic [DW-1:0] ALUResult;
   logic          Zero;

   int total = 0;
   int bad   = 0;

   alu_seq_exec #(.DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .Operation (Operation),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .busy      (busy),
      .done      (done),
      .ALUResult (ALUResult),
      .Zero      (Zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]    op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] exp_res;
      int            exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: results from plain shift/compare operators.
   function automatic logic [DW-1:0] ref_result(input logic [3:0] op, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
      int sh;
      sh = int'(b % DW);
      case (op)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd3:    return a ^ b;
         4'd4:    return a << sh;
         4'd5:    return a >> sh;
         4'd6:    return a - b;
         4'd7:    return DW'($signed(a) >>> sh);
         4'd8:    return (a == b) ? 1 : 0;
         4'd12:   return ($signed(a) < $signed(b)) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   function automatic int ref_latency(input logic [3:0] op, input logic [DW-1:0] b);
      int sh;
      sh = int'(b % DW);
      if ((op == 4'd4 || op == 4'd5 || op == 4'd7) && sh != 0) return sh + 1;
      return 1;
   endfunction

   // Issue one op in the current (idle) cycle, scramble inputs while busy, check completion.
   task automatic run_op(input string name, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] exp_res, input int exp_lat);
      int cyc;
      logic busy_ok;
      busy_ok   = 1'b1;
      start     = 1'b1;
      Operation = op;
      SrcA      = a;
      SrcB      = b;
      tick();
      start = 1'b0;
      cyc   = 1;
      while (done !== 1'b1 && cyc < BUDGET) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         Operation = 4'($urandom);
         SrcA      = $urandom;
         SrcB      = $urandom;
         tick();
         cyc++;
      end
      if (done !== 1'b1) begin
         check({name, "_timeout"}, 32'(done), 32'd1);
         return;
      end
      check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
      check({name, "_busy"}, 32'(busy_ok & busy), 32'd1);
      check({name, "_result"}, ALUResult, exp_res);
      check({name, "_zero"}, 32'(Zero), 32'(exp_res == 0));
      tick();
      check({name, "_after_done"}, {30'd0, busy, done}, 32'd0);
      check({name, "_held"}, ALUResult, exp_res);
   endtask

   vec_t vecs[$];

   initial begin
      logic [15:0] done_seen;
      logic [15:0] done_exp;
      logic        any_done;
      logic [3:0]  op_pool[11];

      reset     = 1'b1;
      start     = 1'b0;
      Operation = '0;
      SrcA      = '0;
      SrcB      = '0;
      repeat (3) tick();
      check("reset_state", {ALUResult[29:0], Zero, busy | done}, 32'd0);
      check("reset_result", ALUResult, 32'd0);
      reset = 1'b0;
      tick();

      vecs.push_back('{4'b0010, 32'd5,          32'd7,          32'd12,         1});
      vecs.push_back('{4'b0110, 32'd3,          32'd5,          32'hFFFF_FFFE,  1});
      vecs.push_back('{4'b1000, 32'h1234,       32'h1234,       32'd1,          1});
      vecs.push_back('{4'b0110, 32'd9,          32'd9,          32'd0,          1});
      vecs.push_back('{4'b1100, 32'hFFFF_FFFF,  32'd0,          32'd1,          1});
      vecs.push_back('{4'b1100, 32'd0,          32'hFFFF_FFFF,  32'd0,          1});
      vecs.push_back('{4'b1111, 32'd5,          32'd6,          32'd0,          1});
      vecs.push_back('{4'b0000, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1});
      vecs.push_back('{4'b0001, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  1});
      vecs.push_back('{4'b0011, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0,  1});
      vecs.push_back('{4'b0100, 32'd1,          32'd31,         32'h8000_0000,  32});
      vecs.push_back('{4'b0111, 32'h8000_0000,  32'd4,          32'hF800_0000,  5});
      vecs.push_back('{4'b0101, 32'hDEAD_BEEF,  32'h20,         32'hDEAD_BEEF,  1});
      vecs.push_back('{4'b0101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd1,          32});
      vecs.push_back('{4'b1000, 32'd1,          32'd2,          32'd0,          1});

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat);

      op_pool = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12, 4'd10};
      for (int i = 0; i < 40; i++) begin
         logic [3:0]    op;
         logic [DW-1:0] a;
         logic [DW-1:0] b;
         op = op_pool[$urandom_range(10, 0)];
         a  = $urandom;
         b  = (i % 4 == 0) ? a : $urandom;
         run_op($sformatf("rnd%0d", i), op, a, b, ref_result(op, a, b), ref_latency(op, b));
      end

      // Start while busy is ignored, including in the done cycle.
      start = 1'b1; Operation = 4'b0101; SrcA = 32'hFFFF_FFFF; SrcB = 32'd8;
      done_seen = '0;
      done_exp  = 16'h0200;
      for (int c = 1; c <= 12; c++) begin
         tick();
         done_seen[c] = done;
         start     = (c == 2 || c == 9);
         Operation = 4'b0010;
         SrcA      = 32'd1;
         SrcB      = 32'd1;
         if (c == 9) check("ignore_result", ALUResult, 32'h00FF_FFFF);
      end
      start = 1'b0;
      check("ignore_done_pattern", 32'(done_seen), 32'(done_exp));
      check("ignore_held", ALUResult, 32'h00FF_FFFF);

      // Reset mid-shift aborts with no done pulse.
      start = 1'b1; Operation = 4'b0100; SrcA = 32'd1; SrcB = 32'd20;
      tick();
      start = 1'b0;
      repeat (5) tick();
      check("abort_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_state", {30'd0, busy, done}, 32'd0);
      check("abort_result", ALUResult, 32'd0);
      check("abort_zero", 32'(Zero), 32'd0);
      any_done = 1'b0;
      for (int c = 0; c < 30; c++) begin
         any_done |= done;
         tick();
      end
      check("abort_no_done", 32'(any_done), 32'd0);
      run_op("after_abort_add", 4'b0010, 32'd2, 32'd3, 32'd5, 1);

      // Reset and start together: reset wins, request dropped.
      reset = 1'b1; start = 1'b1; Operation = 4'b0010; SrcA = 32'd1; SrcB = 32'd1;
      tick();
      reset = 1'b0; start = 1'b0;
      check("rst_start_state", {30'd0, busy, done}, 32'd0);
      check("rst_start_result", ALUResult, 32'd0);
      tick();
      check("rst_start_dropped", {30'd0, busy, done}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

Sequential ALU execute unit, directly downstream of the ALU operation decoder: consumes the 4-bit `Operation` code plus two operands and produces a registered result. Logic/arithmetic/compare ops complete in one cycle. Shifts run on an iterative one-bit-per-cycle shifter, trading shift latency for area, so the unit has a start/busy/done handshake toward the core's control FSM.

## Interface
- `DATA_WIDTH`, 32: operand and result width; shift amount width `SHAMT_W = $clog2(DATA_WIDTH)` is derived.
- `clk`  input  1  rising-edge clock; all state changes on this edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only when `busy`=0.
- `Operation`  input  4  operation code from the ALU operation decoder.
- `SrcA`  input  DATA_WIDTH  operand A.
- `SrcB`  input  DATA_WIDTH  operand B; `SrcB[SHAMT_W-1:0]` is the shift amount.
- `busy`  output  1  high whenever state ≠ IDLE.
- `done`  output  1  one-cycle pulse, result valid.
- `ALUResult`  output  DATA_WIDTH  registered result, held until the next completion.
- `Zero`  output  1  registered, updated with `ALUResult`: 1 iff new `ALUResult`==0.

## Operation
- Codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 SLL
  - 0101 SRL
  - 0110 SUB
  - 0111 SRA
  - 1000 EQ: result 1 if A==B, else 0
  - 1100 SLT: signed A<B gives 1, else 0
- All other codes produce result 0 with single-cycle latency.
- ADD/SUB wrap modulo 2^DATA_WIDTH; no carry or overflow outputs.
- On start acceptance, latch `Operation`, `SrcA`, and shift amount. Later input changes have no effect.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE & start & non-shift op (or shift with amount 0): write result, go to DONE.
  - IDLE & start & shift op with amount N>0: load A into the shift register, count=N, go to SHIFT.
  - SHIFT: shift one bit per cycle and decrement count.
    - SLL fills with 0, SRL fills with 0, SRA replicates the MSB.
    - When the count-1 step completes, write the result and go to DONE.
  - DONE: `done`=1, go to IDLE unconditionally.
- `start` while `busy`=1 is ignored: no queueing, no error.
- Shift amount uses only the low SHAMT_W bits of `SrcB`; upper bits are ignored.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `ALUResult`=0, `Zero`=0, counter 0.
- Start sampled at edge of cycle 0 (cycle 0 is when `start` is high in IDLE).
- Non-shift op, or shift with amount 0: `done` and new `ALUResult`/`Zero` appear in cycle 1.
- Shift with amount N: SHIFT occupies cycles 1..N; `done` and result appear in cycle N+1. Worst case is N=DATA_WIDTH-1, giving `done` in cycle DATA_WIDTH.
- `busy` is high from cycle 1 through the `done` cycle inclusive. Earliest next accepted start is the cycle after `done`, so the minimum issue interval is 2 cycles.
- `ALUResult`/`Zero` change only on the edge entering DONE and are otherwise stable.
- Reset asserted at any point, including mid-SHIFT or in DONE: next cycle matches the reset values. No `done` is generated for the aborted op, and `ALUResult` is cleared.
- `start` and `reset` high in the same cycle: reset wins and the request is dropped.

## Test plan
- Reset, then ADD A=5, B=7 → cycle 1: `done`=1, `ALUResult`=12, `Zero`=0; cycle 2: `done`=0, `busy`=0, result held at 12.
- SUB A=3, B=5 → `ALUResult`=0xFFFFFFFE. Then EQ A=B=0x1234 → result 1. Then SUB A=B=9 → result 0, `Zero`=1.
- SLT: A=0xFFFFFFFF, B=0 → 1. Then A=0, B=0xFFFFFFFF → 0. Then unused code 1111 → result 0 in cycle 1.
- Shift latencies, each checked with `busy` high until `done`:
  - SLL A=1, B=31 → `done` exactly at cycle 32, result 0x80000000.
  - SRA A=0x80000000, B=4 → cycle 5, 0xF8000000.
  - SRL with B=0x20 (amount 0) → cycle 1, result =A.
- Start SRL A=0xFFFFFFFF, B=8. Pulse `start` with an ADD at cycles 2 and 9 while busy → both ignored; `done` only at cycle 9 with 0x00FFFFFF.
- Start SLL A=1, B=20. Assert `reset` at cycle 6 → cycle 7: `busy`=0, `ALUResult`=0, and no `done` pulse ever appears. A new ADD issued after reset completes normally.
